// File: rtl/bus_pkg.sv
// Shared types and constants for the tri-state bus receive endpoint.
package bus_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;
endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer, reset to 0; latency STAGES edges, no backpressure.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/bus_reader.sv
// Tri-state bus receiver: 4-phase stb/ack capture into a 2-deep FIFO, SYNC_STAGES+1 edge ack latency.
// A full FIFO holds off capture by withholding bus_ack; a strobe stuck high past TIMEOUT aborts the handshake.
module bus_reader
  import bus_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_stb,
  output logic             bus_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             timeout_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] word_cnt
);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic             stb_s;
  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic [15:0]      timer_q, timer_d;
  logic             push, pop, set_err;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_stb),
    .q     (stb_s)
  );

  assign pop = (count_q != 2'd0) && out_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    timer_d = timer_q;
    push    = 1'b0;
    set_err = 1'b0;
    case (state_q)
      IDLE: begin
        // Capture depends on the registered count only; a same-cycle pop does not free a slot.
        if (stb_s && (count_q < 2'(FIFO_DEPTH))) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          timer_d = '0;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!stb_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          set_err = 1'b1;
          ack_d   = 1'b0;
          state_d = WAIT_LOW;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      WAIT_LOW: begin
        if (!stb_s) state_d = IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      timer_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      timer_q <= timer_d;
      if (set_err)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
      if (push) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus_ack     = ack_q;
  assign out_data    = mem[rd_ptr];
  assign out_valid   = (count_q != 2'd0);
  assign timeout_err = err_q;
  assign word_cnt    = cnt_q;
endmodule

// File: tb/tb_bus_reader.sv
// Directed bench for bus_reader: handshake latency, backpressure, timeout, push/pop overlap, async reset, counter wrap.
module tb_bus_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bus_data;
  logic        bus_stb;
  logic        bus_ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        timeout_err;
  logic        clr_err;
  logic [15:0] word_cnt;

  int total = 0;
  int bad   = 0;
  int edges;

  bus_reader #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_data    (bus_data),
    .bus_stb     (bus_stb),
    .bus_ack     (bus_ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .timeout_err (timeout_err),
    .clr_err     (clr_err),
    .word_cnt    (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts rising edges until bus_ack reaches lvl; gives up after 20.
  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    while (bus_ack !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    bus_data = d;
    bus_stb  = 1'b1;
    wait_ack(1'b1, n);
    check("xfer_ack_rise", 32'(n >= 2 && n <= 4), 32'd1);
    bus_stb = 1'b0;
    wait_ack(1'b0, n);
    check("xfer_ack_fall", 32'(n >= 2 && n <= 4), 32'd1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus_data = '0; bus_stb = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    step(2);
    check("rst_ack",   32'(bus_ack),     32'd0);
    check("rst_valid", 32'(out_valid),   32'd0);
    check("rst_data",  32'(out_data),    32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);
    check("rst_cnt",   32'(word_cnt),    32'd0);
    rst_n = 1'b1;
    step(2);

    // single transfer
    bus_data = 8'hA5; bus_stb = 1'b1;
    wait_ack(1'b1, edges);
    check("t1_rise_lat", 32'(edges >= 2 && edges <= 4), 32'd1);
    check("t1_valid",    32'(out_valid), 32'd1);
    check("t1_data",     32'(out_data),  32'hA5);
    check("t1_cnt",      32'(word_cnt),  32'd1);
    bus_stb = 1'b0;
    wait_ack(1'b0, edges);
    check("t1_fall_lat", 32'(edges >= 2 && edges <= 4), 32'd1);
    pop_one();
    check("t1_drained", 32'(out_valid), 32'd0);

    // backpressure: third strobe is held off until a slot frees
    send(8'h01);
    send(8'h02);
    check("bp_head", 32'(out_data), 32'h01);
    bus_data = 8'h03; bus_stb = 1'b1;
    step(10);
    check("bp_no_ack", 32'(bus_ack),  32'd0);
    check("bp_cnt",    32'(word_cnt), 32'd3);
    pop_one();
    wait_ack(1'b1, edges);
    check("bp_ack_after_pop", 32'(edges <= 2), 32'd1);
    check("bp_cnt2", 32'(word_cnt), 32'd4);
    bus_stb = 1'b0;
    wait_ack(1'b0, edges);
    check("bp_order0", 32'(out_data), 32'h02);
    pop_one();
    check("bp_order1", 32'(out_data), 32'h03);
    pop_one();
    check("bp_empty", 32'(out_valid), 32'd0);

    // timeout with strobe stuck high
    bus_data = 8'h5A; bus_stb = 1'b1;
    wait_ack(1'b1, edges);
    edges = 0;
    while (bus_ack === 1'b1 && edges < 20) begin
      step(1);
      edges++;
    end
    check("to_ack_cycles", 32'(edges),       32'd4);
    check("to_err_set",    32'(timeout_err), 32'd1);
    step(10);
    check("to_no_reack", 32'(bus_ack),  32'd0);
    check("to_no_recap", 32'(word_cnt), 32'd5);
    pop_one();
    bus_stb = 1'b0;
    step(4);
    send(8'h77);
    check("to_next_cnt",  32'(word_cnt),    32'd6);
    check("to_next_data", 32'(out_data),    32'h77);
    check("to_sticky",    32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("to_cleared", 32'(timeout_err), 32'd0);
    pop_one();

    // push and pop on the same edge
    send(8'h11);
    bus_data = 8'h22; bus_stb = 1'b1;
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("pp_ack",   32'(bus_ack),   32'd1);
    check("pp_head",  32'(out_data),  32'h22);
    check("pp_valid", 32'(out_valid), 32'd1);
    bus_stb = 1'b0;
    wait_ack(1'b0, edges);
    pop_one();
    check("pp_count1", 32'(out_valid), 32'd0);

    // asynchronous reset while acknowledging
    bus_data = 8'h99; bus_stb = 1'b1;
    wait_ack(1'b1, edges);
    check("rs_pre_ack", 32'(bus_ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_ack",   32'(bus_ack),   32'd0);
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_cnt",   32'(word_cnt),  32'd0);
    bus_stb = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    send(8'h3C);
    check("rs_data", 32'(out_data), 32'h3C);
    check("rs_cnt1", 32'(word_cnt), 32'd1);
    pop_one();

    // counter wrap from a forced start value
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    step(1);
    check("wrap_pre", 32'(word_cnt), 32'hFFFF);
    send(8'hC3);
    check("wrap_post", 32'(word_cnt), 32'h0000);
    check("wrap_data", 32'(out_data), 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
